// File: rtl/csa_accu_feed.sv
`default_nettype none
// ============================================================================
//  Module   : csa_accu_feed
//  Purpose  : Sequential carry-save accumulator that feeds the unsigned
//             adder-multiplier. It sums a group of unsigned operands, one per
//             cycle. The running sum is held in redundant form (sum word XS
//             plus carry word XC), so there is no carry-propagate adder in the
//             loop. A completed group is presented as (XS, XC, Y, CNT). The
//             downstream block then computes P = (XS + XC) * Y.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BW      operand word width
//    widthX  width of A / XS / XC (must be <= widthY)
//    widthY  width of multiplicand YIN / Y
//    widthC  width of the saturating beat counter CNT (>= 2)
//  Ports
//    CLK        in   clock, rising edge
//    RST        in   synchronous active-high reset
//    A          in   operand to accumulate
//    YIN        in   multiplicand, sampled on the first beat of a group
//    IN_VALID   in   operand beat valid
//    IN_LAST    in   beat closes the group (qualified by IN_VALID)
//    IN_READY   out  beat is accepted this cycle when IN_VALID is high
//    XS         out  carry-save sum word
//    XC         out  carry-save carry word
//    Y          out  multiplicand of the group
//    CNT        out  beats in the group, saturating
//    OUT_VALID  out  XS/XC/Y/CNT hold a completed group
//    OUT_READY  in   downstream consumes the group
// ============================================================================
module csa_accu_feed #(
   parameter int BW     = 8,
   parameter int widthX = BW,
   parameter int widthY = BW,
   parameter int widthC = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [widthX-1:0] A,
   input  logic [widthY-1:0] YIN,
   input  logic              IN_VALID,
   input  logic              IN_LAST,
   output logic              IN_READY,
   output logic [widthX-1:0] XS,
   output logic [widthX-1:0] XC,
   output logic [widthY-1:0] Y,
   output logic [widthC-1:0] CNT,
   output logic              OUT_VALID,
   input  logic              OUT_READY
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [0:0] S_ACCU = 1'b0;   // collecting beats, OUT_VALID=0
   localparam logic [0:0] S_HOLD = 1'b1;   // group complete, OUT_VALID=1

   localparam logic [widthC-1:0] c_cnt_max  = {widthC{1'b1}};
   localparam logic [widthC-1:0] c_cnt_zero = {widthC{1'b0}};
   localparam logic [widthC-1:0] c_cnt_one  = {{(widthC-1){1'b0}}, 1'b1};
   localparam logic [widthX-1:0] c_x_zero   = {widthX{1'b0}};
   localparam logic [widthY-1:0] c_y_zero   = {widthY{1'b0}};

   // ------------------------------------------------------------------------
   // Registers and wires
   // ------------------------------------------------------------------------
   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [widthX-1:0] r_xs;
   logic [widthX-1:0] r_xc;
   logic [widthY-1:0] r_y;
   logic [widthC-1:0] r_cnt;

   logic              w_out_valid;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_handshake;
   logic              w_first;
   logic [widthX-1:0] w_xs_cmp;
   logic [widthX-1:0] w_maj;
   logic [widthX-1:0] w_xc_cmp;
   logic [widthC-1:0] w_cnt_inc;

   // ------------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------------
   // Ready is forced low during reset so that no beat can slip in on the
   // reset cycle. Otherwise the block takes a beat whenever the output
   // slot is empty or is being drained this cycle.
   assign w_in_ready  = !RST && (!w_out_valid || OUT_READY);
   assign w_accept    = IN_VALID && w_in_ready;
   assign w_handshake = w_out_valid && OUT_READY;

   // Any beat accepted in HOLD carries the previous group out in the same
   // cycle, so it always opens a fresh group.
   assign w_first     = w_accept && ((r_state == S_HOLD) || (r_cnt == c_cnt_zero));

   // ------------------------------------------------------------------------
   // 3:2 compressor: (XS, XC, A) -> (sum, carry). The carry out of the MSB
   // is discarded, which keeps the pair exact modulo 2^widthX.
   // ------------------------------------------------------------------------
   assign w_xs_cmp  = r_xs ^ r_xc ^ A;
   assign w_maj     = (r_xs & r_xc) | (r_xs & A) | (r_xc & A);
   assign w_xc_cmp  = w_maj << 1;

   // Saturating beat counter increment.
   assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

   // ------------------------------------------------------------------------
   // FSM process 1: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_ACCU;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ACCU: begin
            if (w_accept && IN_LAST) begin
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            // A beat in HOLD is only accepted together with a handshake.
            // A new single-beat group then goes straight back to HOLD.
            if (w_handshake) begin
               w_state_nxt = (w_accept && IN_LAST) ? S_HOLD : S_ACCU;
            end
         end
         default: begin
            w_state_nxt = S_ACCU;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM process 3: output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_out_valid = 1'b0;
      case (r_state)
         S_HOLD:  w_out_valid = 1'b1;
         default: w_out_valid = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_xs  <= c_x_zero;
         r_xc  <= c_x_zero;
         r_y   <= c_y_zero;
         r_cnt <= c_cnt_zero;
      end else if (w_first) begin
         r_xs  <= A;
         r_xc  <= c_x_zero;
         r_y   <= YIN;
         r_cnt <= c_cnt_one;
      end else if (w_accept) begin
         r_xs  <= w_xs_cmp;
         r_xc  <= w_xc_cmp;
         r_cnt <= w_cnt_inc;
      end else if (w_handshake) begin
         // The group has been consumed. XS/XC/Y keep stale values that are
         // don't-care. Clearing CNT makes the next beat a first beat.
         r_cnt <= c_cnt_zero;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign IN_READY  = w_in_ready;
   assign XS        = r_xs;
   assign XC        = r_xc;
   assign Y         = r_y;
   assign CNT       = r_cnt;
   assign OUT_VALID = w_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_csa_accu_feed.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_accu_feed
//  Purpose  : Directed self-checking bench for csa_accu_feed. The main
//             instance uses the defaults (8-bit). A second instance uses a
//             2-bit beat counter to exercise counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_accu_feed;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] yin;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic [7:0] xs;
   logic [7:0] xc;
   logic [7:0] y;
   logic [7:0] cnt;
   logic       out_valid;
   logic       out_ready;

   logic [7:0] s_a;
   logic       s_valid;
   logic       s_last;
   logic       s_in_ready;
   logic [7:0] s_xs;
   logic [7:0] s_xc;
   logic [7:0] s_y;
   logic [1:0] s_cnt;
   logic       s_out_valid;

   integer checks;
   integer failures;

   csa_accu_feed u_dut (
      .CLK(clk), .RST(rst), .A(a), .YIN(yin), .IN_VALID(in_valid),
      .IN_LAST(in_last), .IN_READY(in_ready), .XS(xs), .XC(xc), .Y(y),
      .CNT(cnt), .OUT_VALID(out_valid), .OUT_READY(out_ready)
   );

   csa_accu_feed #(.BW(8), .widthC(2)) u_sat (
      .CLK(clk), .RST(rst), .A(s_a), .YIN(8'd1), .IN_VALID(s_valid),
      .IN_LAST(s_last), .IN_READY(s_in_ready), .XS(s_xs), .XC(s_xc), .Y(s_y),
      .CNT(s_cnt), .OUT_VALID(s_out_valid), .OUT_READY(1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock. Inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = 8'd0; yin = 8'd0;
      out_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_a = 8'd0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1; in_valid = 1'b1; a = 8'd77; in_last = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0d exp=0", in_ready); end
      step();
      checks++; if (xs !== 8'd0) begin failures++; $display("FAIL reset_xs got=%0d exp=0", xs); end
      checks++; if (xc !== 8'd0) begin failures++; $display("FAIL reset_xc got=%0d exp=0", xc); end
      checks++; if (y !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
      checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0d exp=1", in_ready); end
   endtask

   task automatic test_basic_group();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; a = 8'd3; yin = 8'd4; in_last = 1'b0;
      step();
      checks++; if ({xs, xc, cnt, out_valid} !== {8'd3, 8'd0, 8'd1, 1'b0}) begin failures++;
         $display("FAIL basic_beat1 got xs=%0d xc=%0d cnt=%0d ov=%0d exp 3 0 1 0", xs, xc, cnt, out_valid); end
      a = 8'd5; yin = 8'd99;
      step();
      checks++; if ({xs, xc, y, cnt} !== {8'd6, 8'd2, 8'd4, 8'd2}) begin failures++;
         $display("FAIL basic_beat2 got xs=%0d xc=%0d y=%0d cnt=%0d exp 6 2 4 2", xs, xc, y, cnt); end
      a = 8'd7; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if ({xs, xc, y, cnt, out_valid} !== {8'd3, 8'd12, 8'd4, 8'd3, 1'b1}) begin failures++;
         $display("FAIL basic_result got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp 3 12 4 3 1", xs, xc, y, cnt, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold_ready got=%0d exp=0", in_ready); end
      // Drain without a new beat: back to ACCU with CNT cleared.
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if ({cnt, out_valid} !== {8'd0, 1'b0}) begin failures++;
         $display("FAIL basic_drain got cnt=%0d ov=%0d exp 0 0", cnt, out_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      in_valid = 1'b1; a = 8'd200; yin = 8'd2; in_last = 1'b0;
      step();
      a = 8'd100; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if ({xs, xc, cnt, out_valid} !== {8'd172, 8'd128, 8'd2, 1'b1}) begin failures++;
         $display("FAIL wrap_pair got xs=%0d xc=%0d cnt=%0d ov=%0d exp 172 128 2 1", xs, xc, cnt, out_valid); end
      checks++; if (8'(xs + xc) !== 8'd44) begin failures++;
         $display("FAIL wrap_sum got=%0d exp=44", 8'(xs + xc)); end
   endtask

   // Runs after test_wrap: the block is in HOLD with (172, 128, y=2, cnt=2).
   task automatic test_backpressure();
      in_valid = 1'b1; a = 8'd9; yin = 8'd6; in_last = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%0d exp=0", i, in_ready); end
         step();
         checks++; if ({xs, xc, y, cnt, out_valid} !== {8'd172, 8'd128, 8'd2, 8'd2, 1'b1}) begin failures++;
            $display("FAIL bp_stable cyc=%0d got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp 172 128 2 2 1", i, xs, xc, y, cnt, out_valid); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0d exp=1", in_ready); end
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if ({xs, xc, y, cnt, out_valid} !== {8'd9, 8'd0, 8'd6, 8'd1, 1'b0}) begin failures++;
         $display("FAIL bp_newgroup got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp 9 0 6 1 0", xs, xc, y, cnt, out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_last = 1'b1; a = vals[i]; yin = 8'd10 + 8'(i);
         step();
         checks++; if ({xs, xc, y, cnt, out_valid} !== {vals[i], 8'd0, 8'd10 + 8'(i), 8'd1, 1'b1}) begin failures++;
            $display("FAIL b2b_group%0d got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp %0d 0 %0d 1 1",
                     i, xs, xc, y, cnt, out_valid, vals[i], 10 + i); end
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
      out_ready = 1'b0;
      checks++; if ({cnt, out_valid} !== {8'd0, 1'b0}) begin failures++;
         $display("FAIL b2b_drain got cnt=%0d ov=%0d exp 0 0", cnt, out_valid); end
   endtask

   task automatic test_reset_mid_group();
      do_reset();
      in_valid = 1'b1; a = 8'd10; yin = 8'd5; in_last = 1'b0;
      step();
      a = 8'd20;
      step();
      checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL rmid_pre_cnt got=%0d exp=2", cnt); end
      rst = 1'b1; a = 8'd30; in_last = 1'b1;
      step();
      rst = 1'b0;
      checks++; if ({xs, xc, y, cnt, out_valid} !== {8'd0, 8'd0, 8'd0, 8'd0, 1'b0}) begin failures++;
         $display("FAIL rmid_cleared got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp 0 0 0 0 0", xs, xc, y, cnt, out_valid); end
      a = 8'd1; yin = 8'd3; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if ({xs, xc, y, cnt, out_valid} !== {8'd1, 8'd0, 8'd3, 8'd1, 1'b1}) begin failures++;
         $display("FAIL rmid_after got xs=%0d xc=%0d y=%0d cnt=%0d ov=%0d exp 1 0 3 1 1", xs, xc, y, cnt, out_valid); end
   endtask

   task automatic test_idle_and_stray_last();
      do_reset();
      in_valid = 1'b1; a = 8'd4; yin = 8'd8; in_last = 1'b0;
      step();
      // IN_LAST without IN_VALID must be ignored; state must hold.
      in_valid = 1'b0; in_last = 1'b1; a = 8'd55;
      step(); step();
      checks++; if ({xs, xc, cnt, out_valid} !== {8'd4, 8'd0, 8'd1, 1'b0}) begin failures++;
         $display("FAIL idle_hold got xs=%0d xc=%0d cnt=%0d ov=%0d exp 4 0 1 0", xs, xc, cnt, out_valid); end
      in_last = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      s_a = 8'd1; s_valid = 1'b1; s_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_last = (i == 4);
         step();
         if (i == 2) begin
            checks++; if (s_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=3", s_cnt); end
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      checks++; if ({s_xs, s_xc, s_cnt, s_out_valid} !== {8'd1, 8'd4, 2'd3, 1'b1}) begin failures++;
         $display("FAIL sat_final got xs=%0d xc=%0d cnt=%0d ov=%0d exp 1 4 3 1", s_xs, s_xc, s_cnt, s_out_valid); end
      checks++; if (9'(s_xs) + 9'(s_xc) !== 9'd5) begin failures++;
         $display("FAIL sat_sum got=%0d exp=5", 9'(s_xs) + 9'(s_xc)); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      #1;
      test_reset();
      test_basic_group();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_group();
      test_idle_and_stray_last();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
